// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, FSM state
// encoding and a round-robin pointer helper.
package alu_arb_pkg;

    localparam int ALU_CTRL_W = 4;

    // ALU control codes understood by the downstream ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

    // Arbiter FSM: accept in IDLE, let the ALU settle in EXEC, hold result in RESP
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Index following idx in a ring of n entries
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: request valid/ready with operands,
// one-hot response valid/ready with a shared result bus.
// Optional feature macro: ALU_ARB_LOCK_EN adds req_lock (per-requester lock).
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [ALU_CTRL_W*NUM_REQ-1:0] req_ctrl;
    logic [DATA_W*NUM_REQ-1:0]     req_a;
    logic [DATA_W*NUM_REQ-1:0]     req_b;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_W-1:0]             rsp_data;
    logic                          rsp_zero;
`ifdef ALU_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            req_lock;

    // Requesting units
    modport master (
        output req_valid, req_ctrl, req_a, req_b, rsp_ready, req_lock,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    // The arbiter
    modport slave (
        input  req_valid, req_ctrl, req_a, req_b, rsp_ready, req_lock,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
`else
    // Requesting units
    modport master (
        output req_valid, req_ctrl, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    // The arbiter
    modport slave (
        input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
`endif

endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick_from;

    // Requests at or above the pointer take priority; otherwise wrap to the bottom
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (gi >= int'(ptr));
        end
    endgenerate

    assign upper_req = req & upper_mask;
    assign pick_from = (|upper_req) ? upper_req : req;
    assign any       = |req;

    // Lowest set bit of the selected window wins
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_from[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = any && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// ALU arbiter: shares one ALU between NUM_REQ requesters with round-robin
// grant, one operation in flight, response held until consumed.
// Optional feature macro: ALU_ARB_LOCK_EN (req_lock keeps the grant with the
// current requester across its response handshake).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_arbiter_if.slave          bus,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t               state_reg;
    logic [IDX_W-1:0]         grant_reg;
    logic [IDX_W-1:0]         rr_ptr_reg;
    logic [NUM_REQ-1:0]       rsp_valid_reg;
    logic [DATA_W-1:0]        rsp_data_reg;
    logic                     rsp_zero_reg;
    logic [ALU_CTRL_W-1:0]    alu_ctrl_reg;
    logic [DATA_W-1:0]        alu_a_reg;
    logic [DATA_W-1:0]        alu_b_reg;

    logic [NUM_REQ-1:0]       arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_any;
    logic [NUM_REQ-1:0]       grant_oh;
    logic [IDX_W-1:0]         rr_ptr_next;
    logic [ALU_CTRL_W-1:0]    ctrl_arr [NUM_REQ];
    logic [DATA_W-1:0]        a_arr    [NUM_REQ];
    logic [DATA_W-1:0]        b_arr    [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Split the flat request buses into per-requester slices
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign ctrl_arr[gi] = bus.req_ctrl[gi*ALU_CTRL_W +: ALU_CTRL_W];
            assign a_arr[gi]    = bus.req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]    = bus.req_b[gi*DATA_W +: DATA_W];
            assign grant_oh[gi] = (grant_reg == IDX_W'(gi));
        end
    endgenerate

    // Pointer after a completed op: advance past the winner unless it holds a lock
    always_comb begin
        rr_ptr_next = IDX_W'(rr_next(32'(grant_reg), NUM_REQ));
`ifdef ALU_ARB_LOCK_EN
        if (bus.req_lock[grant_reg]) begin
            rr_ptr_next = grant_reg;
        end
`endif
    end

    // Accept is combinational in IDLE only; held low while reset is asserted
    assign bus.req_ready = (rst_n && state_reg == IDLE) ? arb_grant : '0;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_zero  = rsp_zero_reg;
    assign alu_ctrl      = alu_ctrl_reg;
    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;

    // Arbitration FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_zero_reg  <= 1'b0;
            alu_ctrl_reg  <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        grant_reg    <= arb_idx;
                        alu_ctrl_reg <= ctrl_arr[arb_idx];
                        alu_a_reg    <= a_arr[arb_idx];
                        alu_b_reg    <= b_arr[arb_idx];
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= alu_result;
                    rsp_zero_reg  <= alu_zero;
                    rsp_valid_reg <= grant_oh;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[grant_reg]) begin
                        rsp_valid_reg <= '0;
                        rr_ptr_reg    <= rr_ptr_next;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
